// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath.
// Master side is the FSM; slave side is the datapath/cache.
interface multicycle_control_fsm_if;
  logic [6:0] OP;
  logic       ZERO;
  logic       CACHE_STALL;
  logic       PC_WRITE;
  logic       PC_UPDATE;
  logic       BRANCH;
  logic       REG_WRITE;
  logic       MEM_WRITE;
  logic       MEM_RD;
  logic       IR_WRITE;
  logic       ADR_SRC;
  logic [1:0] RESULT_SRC;
  logic [1:0] ALU_SRC_A;
  logic [1:0] ALU_SRC_B;
  logic [1:0] ALUOP1_0;
  logic       ILLEGAL_OP;
  logic [3:0] STATE;

  modport master (
    input  OP, ZERO, CACHE_STALL,
    output PC_WRITE, PC_UPDATE, BRANCH,
    output REG_WRITE, MEM_WRITE, MEM_RD,
    output IR_WRITE, ADR_SRC, RESULT_SRC,
    output ALU_SRC_A, ALU_SRC_B, ALUOP1_0,
    output ILLEGAL_OP, STATE
  );

  modport slave (
    output OP, ZERO, CACHE_STALL,
    input  PC_WRITE, PC_UPDATE, BRANCH,
    input  REG_WRITE, MEM_WRITE, MEM_RD,
    input  IR_WRITE, ADR_SRC, RESULT_SRC,
    input  ALU_SRC_A, ALU_SRC_B, ALUOP1_0,
    input  ILLEGAL_OP, STATE
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath.
// Moore-decoded strobes; holds state while the cache is stalled.
module multicycle_control_fsm (
  input  logic CLK,
  input  logic RST,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t state_q;
  state_t state_d;

  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic       mem_write;
  logic       mem_rd;
  logic       ir_write;
  logic       illegal;
  logic       stall;

  assign stall = bus.CACHE_STALL;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = S_FETCH;
    pc_update      = 1'b0;
    branch         = 1'b0;
    reg_write      = 1'b0;
    mem_write      = 1'b0;
    mem_rd         = 1'b0;
    ir_write       = 1'b0;
    illegal        = 1'b0;
    bus.ADR_SRC    = 1'b0;
    bus.RESULT_SRC = 2'b00;
    bus.ALU_SRC_A  = 2'b00;
    bus.ALU_SRC_B  = 2'b00;
    bus.ALUOP1_0   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd         = 1'b1;
        bus.ALU_SRC_B  = 2'b10;
        bus.RESULT_SRC = 2'b10;
        ir_write       = !stall;
        pc_update      = !stall;
        state_d        = stall ? S_FETCH : S_DECODE;
      end
      S_DECODE: begin
        bus.ALU_SRC_A = 2'b01;
        bus.ALU_SRC_B = 2'b01;
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALU_SRC_A = 2'b10;
        bus.ALU_SRC_B = 2'b01;
        state_d = bus.OP[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.ADR_SRC = 1'b1;
        mem_rd      = 1'b1;
        state_d     = stall ? S_MEMREAD : S_MEMWB;
      end
      S_MEMWB: begin
        bus.RESULT_SRC = 2'b01;
        reg_write      = 1'b1;
      end
      S_MEMWRITE: begin
        bus.ADR_SRC = 1'b1;
        mem_write   = 1'b1;
        state_d     = stall ? S_MEMWRITE : S_FETCH;
      end
      S_EXECR: begin
        bus.ALU_SRC_A = 2'b10;
        bus.ALUOP1_0  = 2'b10;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALU_SRC_A = 2'b10;
        bus.ALU_SRC_B = 2'b01;
        bus.ALUOP1_0  = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        bus.ALU_SRC_A = 2'b01;
        bus.ALU_SRC_B = 2'b10;
        pc_update     = 1'b1;
        state_d       = S_ALUWB;
      end
      S_BEQ: begin
        bus.ALU_SRC_A = 2'b10;
        bus.ALUOP1_0  = 2'b01;
        branch        = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so FETCH's MEM_RD never leaks while held.
  always_comb begin
    bus.PC_UPDATE  = pc_update & RST;
    bus.BRANCH     = branch & RST;
    bus.REG_WRITE  = reg_write & RST;
    bus.MEM_WRITE  = mem_write & RST;
    bus.MEM_RD     = mem_rd & RST;
    bus.IR_WRITE   = ir_write & RST;
    bus.ILLEGAL_OP = illegal & RST;
    bus.PC_WRITE   = (pc_update | (branch & bus.ZERO)) & RST;
    bus.STATE      = state_q;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm.
// Output vector: pcw pcu br rw mw mr ir adr | rs | a | b | aop | ill
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam logic [16:0] O_RST = 17'b0000_0000_10_00_10_00_0;
  localparam logic [16:0] O_F   = 17'b1100_0110_10_00_10_00_0;
  localparam logic [16:0] O_FS  = 17'b0000_0100_10_00_10_00_0;
  localparam logic [16:0] O_DEC = 17'b0000_0000_00_01_01_00_0;
  localparam logic [16:0] O_DIL = 17'b0000_0000_00_01_01_00_1;
  localparam logic [16:0] O_MA  = 17'b0000_0000_00_10_01_00_0;
  localparam logic [16:0] O_MR  = 17'b0000_0101_00_00_00_00_0;
  localparam logic [16:0] O_MWB = 17'b0001_0000_01_00_00_00_0;
  localparam logic [16:0] O_MW  = 17'b0000_1001_00_00_00_00_0;
  localparam logic [16:0] O_ER  = 17'b0000_0000_00_10_00_10_0;
  localparam logic [16:0] O_EI  = 17'b0000_0000_00_10_01_10_0;
  localparam logic [16:0] O_AWB = 17'b0001_0000_00_00_00_00_0;
  localparam logic [16:0] O_JAL = 17'b1100_0000_00_01_10_00_0;
  localparam logic [16:0] O_BQ1 = 17'b1010_0000_00_10_00_01_0;
  localparam logic [16:0] O_BQ0 = 17'b0010_0000_00_10_00_01_0;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        stall;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  logic [16:0] act;
  assign act = {bus.PC_WRITE, bus.PC_UPDATE, bus.BRANCH,
                bus.REG_WRITE, bus.MEM_WRITE, bus.MEM_RD,
                bus.IR_WRITE, bus.ADR_SRC, bus.RESULT_SRC,
                bus.ALU_SRC_A, bus.ALU_SRC_B, bus.ALUOP1_0,
                bus.ILLEGAL_OP};

  function automatic void add(logic [6:0] op, logic z, logic s,
                              logic [3:0] st, logic [16:0] o);
    vec_t v;
    v = '{op: op, zero: z, stall: s, st: st, out: o};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] st,
                       input logic [16:0] o);
    total++;
    if (bus.STATE === st) passed++;
    else $display("FAIL %s state: got %0d expected %0d",
                  name, bus.STATE, st);
    total++;
    if (act === o) passed++;
    else $display("FAIL %s outputs: got %b expected %b",
                  name, act, o);
  endtask

  task automatic step(input string name, input logic [6:0] op,
                      input logic z, input logic s,
                      input logic [3:0] st, input logic [16:0] o);
    bus.OP = op;
    bus.ZERO = z;
    bus.CACHE_STALL = s;
    @(negedge clk);
    check(name, st, o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // R-type
    add(RT, 0, 0, 0, O_F);  add(RT, 0, 0, 1, O_DEC);
    add(RT, 0, 0, 6, O_ER); add(RT, 0, 0, 8, O_AWB);
    // I-type; stall in DECODE must be ignored
    add(IT, 0, 0, 0, O_F);  add(IT, 0, 1, 1, O_DEC);
    add(IT, 0, 0, 7, O_EI); add(IT, 0, 0, 8, O_AWB);
    // jal
    add(JL, 0, 0, 0, O_F);   add(JL, 0, 0, 1, O_DEC);
    add(JL, 0, 0, 9, O_JAL); add(JL, 0, 0, 8, O_AWB);
    // beq taken / not taken
    add(BQ, 1, 0, 0, O_F);   add(BQ, 1, 0, 1, O_DEC);
    add(BQ, 1, 0, 10, O_BQ1);
    add(BQ, 0, 0, 0, O_F);   add(BQ, 0, 0, 1, O_DEC);
    add(BQ, 0, 0, 10, O_BQ0);
    // illegal
    add(BAD, 0, 0, 0, O_F);  add(BAD, 0, 0, 1, O_DIL);
    // sw, lw without stalls
    add(SW, 0, 0, 0, O_F);   add(SW, 0, 0, 1, O_DEC);
    add(SW, 0, 0, 2, O_MA);  add(SW, 0, 0, 5, O_MW);
    add(LW, 0, 0, 0, O_F);   add(LW, 0, 0, 1, O_DEC);
    add(LW, 0, 0, 2, O_MA);  add(LW, 0, 0, 3, O_MR);
    add(LW, 0, 0, 4, O_MWB);

    bus.OP = RT;
    bus.ZERO = 1'b0;
    bus.CACHE_STALL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset", 4'd0, O_RST);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), tbl[i].op, tbl[i].zero,
           tbl[i].stall, tbl[i].st, tbl[i].out);

    // lw: 2 FETCH stalls + 3 MEMREAD stalls = 10 cycles
    step("lw_fs0", LW, 0, 1, 0, O_FS);
    step("lw_fs1", LW, 0, 1, 0, O_FS);
    step("lw_f",   LW, 0, 0, 0, O_F);
    step("lw_d",   LW, 0, 0, 1, O_DEC);
    step("lw_ma",  LW, 0, 0, 2, O_MA);
    step("lw_mr0", LW, 0, 1, 3, O_MR);
    step("lw_mr1", LW, 0, 1, 3, O_MR);
    step("lw_mr2", LW, 0, 1, 3, O_MR);
    step("lw_mr3", LW, 0, 0, 3, O_MR);
    step("lw_wb",  LW, 0, 0, 4, O_MWB);

    // sw: MEM_WRITE held through 2 stalls
    step("sw_f",   SW, 0, 0, 0, O_F);
    step("sw_d",   SW, 0, 0, 1, O_DEC);
    step("sw_ma",  SW, 0, 0, 2, O_MA);
    step("sw_mw0", SW, 0, 1, 5, O_MW);
    step("sw_mw1", SW, 0, 1, 5, O_MW);
    step("sw_mw2", SW, 0, 0, 5, O_MW);
    step("sw_end", RT, 0, 0, 0, O_F);
    step("sw_end_d", RT, 0, 0, 1, O_DEC);
    step("sw_end_e", RT, 0, 0, 6, O_ER);
    step("sw_end_w", RT, 0, 0, 8, O_AWB);

    // reset mid-stall in MEMWRITE
    step("rs_f",  SW, 0, 0, 0, O_F);
    step("rs_d",  SW, 0, 0, 1, O_DEC);
    step("rs_ma", SW, 0, 0, 2, O_MA);
    bus.CACHE_STALL = 1'b1;
    @(negedge clk);
    check("rs_mw", 4'd5, O_MW);
    #2;
    rst = 1'b0;
    #1;
    check("rs_async", 4'd0, O_RST);
    @(posedge clk);
    #1;
    check("rs_hold", 4'd0, O_RST);
    rst = 1'b1;
    step("rs_after", RT, 0, 0, 0, O_F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I datapath with cache-backed memory. It sits directly upstream of the ALU decoder: it decodes the opcode held in the instruction register, sequences each instruction through fetch, decode, execute, memory and writeback states, and drives `ALUOP1_0` into the ALU decoder. It also drives every datapath strobe and mux select, and it holds the current state whenever the cache reports a miss in progress.

## Interface
Parameters:
- none; state encoding and opcodes are fixed (RV32I subset: lw, sw, R-type, I-type ALU, jal, beq).

Ports (reset is asynchronous and active-low; one clock domain):
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous active-low reset
- `OP`  in  7  opcode from instruction register; stable from DECODE until return to FETCH
- `ZERO`  in  1  ALU zero flag
- `CACHE_STALL`  in  1  cache miss being serviced; memory access not complete
- `PC_WRITE`  out  1  PC_UPDATE | (BRANCH & ZERO)
- `PC_UPDATE`  out  1  unconditional PC write
- `BRANCH`  out  1  branch state indicator
- `REG_WRITE`  out  1  register file write enable
- `MEM_WRITE`  out  1  cache write request
- `MEM_RD`  out  1  cache read request
- `IR_WRITE`  out  1  instruction register load
- `ADR_SRC`  out  1  0 = PC, 1 = ALU result as memory address
- `RESULT_SRC`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `ALU_SRC_A`  out  2  00 PC, 01 OldPC, 10 rs1 data
- `ALU_SRC_B`  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- `ALUOP1_0`  out  2  to ALU decoder: 00 add, 01 subtract/compare, 10 funct-decoded
- `ILLEGAL_OP`  out  1  one-cycle pulse: unsupported opcode seen in DECODE
- `STATE`  out  4  current state code, for debug

## Operation
State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10. Codes 11–15 are unreachable and return to FETCH on the next edge.

Transitions:
- FETCH -> DECODE if !CACHE_STALL; otherwise stay in FETCH.
- DECODE, by OP:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other value -> FETCH, with ILLEGAL_OP=1 for that cycle
- MEMADR -> MEMREAD if OP[5]=0, else MEMWRITE.
- MEMREAD -> MEMWB if !CACHE_STALL; otherwise stay.
- MEMWRITE -> FETCH if !CACHE_STALL; otherwise stay.
- MEMWB, ALUWB and BEQ -> FETCH.
- EXECUTER, EXECUTEI and JAL -> ALUWB.

Outputs are Moore-decoded from the state. Fields not listed for a state are 0.
- FETCH: MEM_RD=1, ALU_SRC_B=10, RESULT_SRC=10. IR_WRITE and PC_UPDATE = !CACHE_STALL.
- DECODE: ALU_SRC_A=01, ALU_SRC_B=01.
- MEMADR: ALU_SRC_A=10, ALU_SRC_B=01.
- MEMREAD: ADR_SRC=1, MEM_RD=1.
- MEMWB: RESULT_SRC=01, REG_WRITE=1.
- MEMWRITE: ADR_SRC=1, MEM_WRITE=1, held asserted for every stall cycle.
- EXECUTER: ALU_SRC_A=10, ALUOP1_0=10.
- EXECUTEI: ALU_SRC_A=10, ALU_SRC_B=01, ALUOP1_0=10.
- ALUWB: REG_WRITE=1.
- JAL: ALU_SRC_A=01, ALU_SRC_B=10, PC_UPDATE=1.
- BEQ: ALU_SRC_A=10, ALUOP1_0=01, BRANCH=1.

## Timing
- Reset: while RST=0, the state is forced to FETCH and STATE=0. All strobes are 0: PC_WRITE, PC_UPDATE, REG_WRITE, MEM_WRITE, MEM_RD, IR_WRITE, ILLEGAL_OP. Selects show their FETCH values.
- Reset release: the first FETCH is active on the first rising edge after RST rises.
- Reset asserted mid-instruction (including mid-stall) aborts immediately; no strobe survives into the reset period.
- Latency with no stalls:
  - beq: 3 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - lw: 5 cycles
- Each stall cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- CACHE_STALL is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in every other state.
- Outputs depend only on the state, plus CACHE_STALL (for IR_WRITE and PC_UPDATE in FETCH) and ZERO (for PC_WRITE). There is no registered output delay.
- Only one state transition occurs per edge. No instruction overlaps another.

## Test plan
- Reset: hold RST=0 for 3 cycles with OP=0110011 -> STATE=0 and all strobes 0. After release, IR_WRITE=PC_UPDATE=MEM_RD=1 in the first cycle.
- R-type: OP=0110011, no stall -> STATE sequence 0,1,6,8,0. ALUOP1_0=10 in state 6; REG_WRITE=1 only in state 8.
- lw with stalls: OP=0000011, CACHE_STALL=1 for 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 cycles in total. IR_WRITE=0 during the FETCH stall; MEM_RD held high throughout the stalls.
- sw with stall: OP=0100011, CACHE_STALL=1 for 2 cycles in MEMWRITE -> MEM_WRITE high for 3 consecutive cycles, then STATE=0.
- beq: ZERO=1 -> PC_WRITE=1 and ALUOP1_0=01 in state 10. Repeat with ZERO=0 -> PC_WRITE=0. Both cases return to FETCH after 3 cycles.
- Illegal opcode and mid-instruction reset: OP=1111111 -> ILLEGAL_OP pulses for 1 cycle in DECODE, then STATE=0. Asserting RST=0 in state 5 -> MEM_WRITE drops to 0 asynchronously.
